// File: rtl/mcb_line_reader.sv
`default_nettype none
// ============================================================================
//  Module      : mcb_line_reader
//  Description : Fetches one video line per request from an MCB read port and
//                forwards the words to a downstream line FIFO. Burst length,
//                bursts per line, lines per frame, line stride and two frame
//                buffer bases are run-time configuration. Supports
//                double-buffer frame selection, downstream backpressure and
//                sticky request-overrun detection.
//
//  Ports
//    memclk, mem_rst_n        : clock, asynchronous active-low reset
//    cfg_*                    : run-time configuration (burst length - 1,
//                               bursts per line, lines per frame, stride,
//                               frame buffer bases)
//    frame_start, frame_sel   : frame restart pulse and buffer select
//    line_req, line_done      : per-line request / completion pulses
//    busy, line_cnt, cur_buf  : status
//    req_ovf                  : sticky request-overrun flag
//    mcb_cmd_*, mcb_rd_*      : MCB command and read-data ports
//    out_data/valid/ready     : downstream FIFO write port
//
//  Revision    : 1.0  initial release
// ============================================================================
module mcb_line_reader #(
    parameter int DWIDTH = 128,
    parameter int AWIDTH = 30,
    parameter int LINE_W = 11,
    parameter int BRST_W = 4
) (
    input  logic              memclk,
    input  logic              mem_rst_n,

    input  logic [5:0]        cfg_bl,
    input  logic [BRST_W-1:0] cfg_brst_num,
    input  logic [LINE_W-1:0] cfg_lines,
    input  logic [AWIDTH-1:0] cfg_stride,
    input  logic [AWIDTH-1:0] cfg_base0,
    input  logic [AWIDTH-1:0] cfg_base1,

    input  logic              frame_start,
    input  logic              frame_sel,
    input  logic              line_req,
    output logic              line_done,
    output logic              busy,
    output logic [LINE_W-1:0] line_cnt,
    output logic              cur_buf,
    output logic              req_ovf,

    output logic              mcb_cmd_en,
    output logic [2:0]        mcb_cmd_instr,
    output logic [5:0]        mcb_cmd_bl,
    output logic [AWIDTH-1:0] mcb_cmd_byte_addr,
    input  logic              mcb_cmd_full,
    output logic              mcb_rd_en,
    input  logic [DWIDTH-1:0] mcb_rd_data,
    input  logic              mcb_rd_empty,

    output logic [DWIDTH-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready
);

    localparam int         C_BYTES      = DWIDTH / 8;
    localparam int         C_BYTE_SHIFT = $clog2(C_BYTES);
    localparam logic [2:0] C_CMD_READ   = 3'b011;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_XFER  = 2'd2
    } state_t;

    state_t              r_state;
    logic                r_req_pend;
    logic                r_frame_pend;
    logic [5:0]          r_bl_sh;
    logic [BRST_W-1:0]   r_brst_sh;
    logic [5:0]          r_word_cnt;
    logic [BRST_W-1:0]   r_brst_cnt;
    logic [AWIDTH-1:0]   r_line_addr;
    logic [AWIDTH-1:0]   r_burst_addr;
    logic [LINE_W-1:0]   r_line_cnt;
    logic                r_cur_buf;
    logic                r_req_ovf;
    logic                r_cmd_en;
    logic                r_line_done;

    logic                w_accept;
    logic                w_last_word;
    logic                w_last_burst;
    logic                w_last_line;
    logic                w_apply_frame;
    logic                w_start_line;
    logic [AWIDTH-1:0]   w_burst_bytes;
    logic [AWIDTH-1:0]   w_sel_base;
    logic [AWIDTH-1:0]   w_cur_base;

    assign w_accept      = (r_state == ST_XFER) & ~mcb_rd_empty & out_ready;
    assign w_last_word   = (r_word_cnt == r_bl_sh);
    assign w_last_burst  = (r_brst_cnt == (r_brst_sh - BRST_W'(1)));
    assign w_last_line   = (r_line_cnt == (cfg_lines - LINE_W'(1)));
    // A pending restart owns the IDLE cycle; a pending request waits one
    // cycle so that it starts from the new frame's line 0 address.
    assign w_apply_frame = (r_state == ST_IDLE) & r_frame_pend;
    assign w_start_line  = (r_state == ST_IDLE) & r_req_pend & ~r_frame_pend;
    assign w_burst_bytes = (AWIDTH'(r_bl_sh) + AWIDTH'(1)) << C_BYTE_SHIFT;
    assign w_sel_base    = frame_sel ? cfg_base1 : cfg_base0;
    assign w_cur_base    = r_cur_buf ? cfg_base1 : cfg_base0;

    always_ff @(posedge memclk or negedge mem_rst_n) begin
        if (!mem_rst_n) begin
            r_state      <= ST_IDLE;
            r_req_pend   <= 1'b0;
            r_frame_pend <= 1'b0;
            r_bl_sh      <= '0;
            r_brst_sh    <= '0;
            r_word_cnt   <= '0;
            r_brst_cnt   <= '0;
            r_line_addr  <= '0;
            r_burst_addr <= '0;
            r_line_cnt   <= '0;
            r_cur_buf    <= 1'b0;
            r_req_ovf    <= 1'b0;
            r_cmd_en     <= 1'b0;
            r_line_done  <= 1'b0;
        end else begin
            r_cmd_en    <= 1'b0;
            r_line_done <= 1'b0;

            // Request latch: a request arriving in the consuming cycle is
            // kept as the next request rather than counted as an overrun.
            if (line_req) begin
                r_req_pend <= 1'b1;
            end else if (w_start_line) begin
                r_req_pend <= 1'b0;
            end

            if (frame_start) begin
                r_frame_pend <= 1'b1;
            end else if (w_apply_frame) begin
                r_frame_pend <= 1'b0;
            end

            // Clear first so an overrun in the same cycle is still recorded.
            if (w_apply_frame) begin
                r_req_ovf <= 1'b0;
            end
            if (line_req && r_req_pend && !w_start_line) begin
                r_req_ovf <= 1'b1;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_apply_frame) begin
                        r_line_cnt  <= '0;
                        r_cur_buf   <= frame_sel;
                        r_line_addr <= w_sel_base;
                    end else if (r_req_pend) begin
                        r_bl_sh      <= cfg_bl;
                        r_brst_sh    <= cfg_brst_num;
                        r_burst_addr <= r_line_addr;
                        r_word_cnt   <= '0;
                        r_brst_cnt   <= '0;
                        r_state      <= ST_ISSUE;
                    end
                end

                ST_ISSUE: begin
                    if (!mcb_cmd_full) begin
                        r_cmd_en <= 1'b1;
                        r_state  <= ST_XFER;
                    end
                end

                ST_XFER: begin
                    if (w_accept) begin
                        if (w_last_word) begin
                            r_word_cnt <= '0;
                            if (w_last_burst) begin
                                r_state     <= ST_IDLE;
                                r_line_done <= 1'b1;
                                if (w_last_line) begin
                                    r_line_cnt  <= '0;
                                    r_line_addr <= w_cur_base;
                                end else begin
                                    r_line_cnt  <= r_line_cnt + LINE_W'(1);
                                    r_line_addr <= r_line_addr + cfg_stride;
                                end
                            end else begin
                                r_brst_cnt   <= r_brst_cnt + BRST_W'(1);
                                r_burst_addr <= r_burst_addr + w_burst_bytes;
                                r_state      <= ST_ISSUE;
                            end
                        end else begin
                            r_word_cnt <= r_word_cnt + 6'd1;
                        end
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign line_done         = r_line_done;
    assign busy              = (r_state != ST_IDLE);
    assign line_cnt          = r_line_cnt;
    assign cur_buf           = r_cur_buf;
    assign req_ovf           = r_req_ovf;
    assign mcb_cmd_en        = r_cmd_en;
    assign mcb_cmd_instr     = C_CMD_READ;
    assign mcb_cmd_bl        = r_bl_sh;
    assign mcb_cmd_byte_addr = r_burst_addr;
    assign mcb_rd_en         = w_accept;
    assign out_valid         = w_accept;
    assign out_data          = mcb_rd_data;

endmodule
`default_nettype wire

// File: tb/tb_mcb_line_reader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mcb_line_reader
//  Description : Self-checking bench for mcb_line_reader. A simple MCB model
//                returns address-derived data for each read command; a
//                line-level reference model predicts commands, data words
//                and line counters from the configuration.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mcb_line_reader;

    localparam int DWIDTH = 128;
    localparam int AWIDTH = 30;
    localparam int LINE_W = 11;
    localparam int BRST_W = 4;
    localparam int BYTES  = DWIDTH / 8;

    logic              memclk = 1'b0;
    logic              mem_rst_n;
    logic [5:0]        cfg_bl;
    logic [BRST_W-1:0] cfg_brst_num;
    logic [LINE_W-1:0] cfg_lines;
    logic [AWIDTH-1:0] cfg_stride;
    logic [AWIDTH-1:0] cfg_base0;
    logic [AWIDTH-1:0] cfg_base1;
    logic              frame_start;
    logic              frame_sel;
    logic              line_req;
    logic              line_done;
    logic              busy;
    logic [LINE_W-1:0] line_cnt;
    logic              cur_buf;
    logic              req_ovf;
    logic              mcb_cmd_en;
    logic [2:0]        mcb_cmd_instr;
    logic [5:0]        mcb_cmd_bl;
    logic [AWIDTH-1:0] mcb_cmd_byte_addr;
    logic              mcb_cmd_full;
    logic              mcb_rd_en;
    logic [DWIDTH-1:0] mcb_rd_data;
    logic              mcb_rd_empty;
    logic [DWIDTH-1:0] out_data;
    logic              out_valid;
    logic              out_ready;

    mcb_line_reader #(
        .DWIDTH(DWIDTH), .AWIDTH(AWIDTH), .LINE_W(LINE_W), .BRST_W(BRST_W)
    ) dut (
        .memclk           (memclk),
        .mem_rst_n        (mem_rst_n),
        .cfg_bl           (cfg_bl),
        .cfg_brst_num     (cfg_brst_num),
        .cfg_lines        (cfg_lines),
        .cfg_stride       (cfg_stride),
        .cfg_base0        (cfg_base0),
        .cfg_base1        (cfg_base1),
        .frame_start      (frame_start),
        .frame_sel        (frame_sel),
        .line_req         (line_req),
        .line_done        (line_done),
        .busy             (busy),
        .line_cnt         (line_cnt),
        .cur_buf          (cur_buf),
        .req_ovf          (req_ovf),
        .mcb_cmd_en       (mcb_cmd_en),
        .mcb_cmd_instr    (mcb_cmd_instr),
        .mcb_cmd_bl       (mcb_cmd_bl),
        .mcb_cmd_byte_addr(mcb_cmd_byte_addr),
        .mcb_cmd_full     (mcb_cmd_full),
        .mcb_rd_en        (mcb_rd_en),
        .mcb_rd_data      (mcb_rd_data),
        .mcb_rd_empty     (mcb_rd_empty),
        .out_data         (out_data),
        .out_valid        (out_valid),
        .out_ready        (out_ready)
    );

    always #5 memclk = ~memclk;

    int checks = 0;
    int errors = 0;

    // MCB model and observation queues
    logic [DWIDTH-1:0] mq[$];
    logic [AWIDTH-1:0] cmd_addr_q[$];
    logic [5:0]        cmd_bl_q[$];
    int                cmd_cyc_q[$];
    logic [DWIDTH-1:0] word_q[$];
    int                word_cyc_q[$];
    int                done_cyc_q[$];
    logic [LINE_W-1:0] done_lc_q[$];
    int                cyc_no = 0;
    bit                rnd_bp = 1'b0;
    int                req_cyc;

    // Reference model
    logic [AWIDTH-1:0] m_addr;
    int                m_line;
    bit                m_buf;
    logic [AWIDTH-1:0] e_cmd_addr[$];
    logic [5:0]        e_cmd_bl[$];
    logic [DWIDTH-1:0] e_word[$];
    logic [LINE_W-1:0] e_lc[$];

    function automatic logic [DWIDTH-1:0] mem_word(input logic [AWIDTH-1:0] a);
        logic [31:0] x;
        x = {2'b00, a};
        return {x, ~x, x * 32'h9E37_79B1, x ^ 32'h5A5A_0F0F};
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock period: drive MCB/downstream inputs, observe, advance.
    task automatic cyc();
        if (rnd_bp) begin
            out_ready    = ($urandom_range(0, 3) != 0);
            mcb_rd_empty = (mq.size() == 0) || ($urandom_range(0, 2) == 0);
        end else begin
            out_ready    = 1'b1;
            mcb_rd_empty = (mq.size() == 0);
        end
        mcb_rd_data = (mq.size() != 0) ? mq[0] : {4{$urandom()}};
        #1;
        if (mcb_rd_en || out_valid) begin
            check("rd_handshake", {mcb_rd_en, out_valid, ~mcb_rd_empty, out_ready}, 4'b1111);
            if (mcb_rd_en && mq.size() != 0) begin
                word_q.push_back(out_data);
                word_cyc_q.push_back(cyc_no);
                void'(mq.pop_front());
            end
        end
        if (mcb_cmd_en) begin
            cmd_addr_q.push_back(mcb_cmd_byte_addr);
            cmd_bl_q.push_back(mcb_cmd_bl);
            cmd_cyc_q.push_back(cyc_no);
            for (int k = 0; k <= int'(mcb_cmd_bl); k++) begin
                mq.push_back(mem_word(mcb_cmd_byte_addr + AWIDTH'(k * BYTES)));
            end
        end
        if (line_done) begin
            done_cyc_q.push_back(cyc_no);
            done_lc_q.push_back(line_cnt);
        end
        @(posedge memclk);
        @(negedge memclk);
        cyc_no++;
    endtask

    task automatic clear_all();
        cmd_addr_q.delete(); cmd_bl_q.delete(); cmd_cyc_q.delete();
        word_q.delete(); word_cyc_q.delete();
        done_cyc_q.delete(); done_lc_q.delete();
        e_cmd_addr.delete(); e_cmd_bl.delete(); e_word.delete(); e_lc.delete();
    endtask

    // Predict one line from the current configuration, then advance.
    task automatic model_line();
        int bw;
        bw = int'(cfg_bl) + 1;
        for (int b = 0; b < int'(cfg_brst_num); b++) begin
            e_cmd_addr.push_back(m_addr + AWIDTH'(b * bw * BYTES));
            e_cmd_bl.push_back(cfg_bl);
        end
        for (int i = 0; i < bw * int'(cfg_brst_num); i++) begin
            e_word.push_back(mem_word(m_addr + AWIDTH'(i * BYTES)));
        end
        if (m_line == int'(cfg_lines) - 1) begin
            m_line = 0;
            m_addr = m_buf ? cfg_base1 : cfg_base0;
        end else begin
            m_line++;
            m_addr = m_addr + cfg_stride;
        end
        e_lc.push_back(LINE_W'(m_line));
    endtask

    task automatic model_restart(input bit sel);
        m_line = 0;
        m_buf  = sel;
        m_addr = sel ? cfg_base1 : cfg_base0;
    endtask

    task automatic pulse_req();
        line_req = 1'b1;
        req_cyc  = cyc_no;
        cyc();
        line_req = 1'b0;
    endtask

    task automatic restart(input bit sel);
        frame_sel   = sel;
        frame_start = 1'b1;
        cyc();
        frame_start = 1'b0;
        repeat (3) cyc();
        model_restart(sel);
    endtask

    task automatic wait_lines(input int n, input int budget);
        int k;
        k = 0;
        while (done_cyc_q.size() < n && k < budget) begin
            cyc();
            k++;
        end
        check("line_done_count", done_cyc_q.size(), n);
    endtask

    task automatic compare_all();
        check("cmd_count", cmd_addr_q.size(), e_cmd_addr.size());
        for (int i = 0; i < cmd_addr_q.size() && i < e_cmd_addr.size(); i++) begin
            check("cmd_addr", cmd_addr_q[i], e_cmd_addr[i]);
            check("cmd_bl", cmd_bl_q[i], e_cmd_bl[i]);
        end
        check("word_count", word_q.size(), e_word.size());
        for (int i = 0; i < word_q.size() && i < e_word.size(); i++) begin
            check("word_data", word_q[i], e_word[i]);
        end
        check("done_count", done_lc_q.size(), e_lc.size());
        for (int i = 0; i < done_lc_q.size() && i < e_lc.size(); i++) begin
            check("line_cnt_at_done", done_lc_q[i], e_lc[i]);
        end
    endtask

    initial begin
        mem_rst_n    = 1'b0;
        cfg_bl       = 6'd7;
        cfg_brst_num = 4'd4;
        cfg_lines    = 11'd4;
        cfg_stride   = 30'h800;
        cfg_base0    = 30'h1000;
        cfg_base1    = 30'h3FFF_FF00;
        frame_start  = 1'b0;
        frame_sel    = 1'b0;
        line_req     = 1'b0;
        mcb_cmd_full = 1'b0;
        out_ready    = 1'b1;
        mcb_rd_empty = 1'b1;
        mcb_rd_data  = '0;
        m_addr = '0; m_line = 0; m_buf = 1'b0;

        // ---------------- reset state
        repeat (2) cyc();
        check("rst_busy", busy, 1'b0);
        check("rst_line_done", line_done, 1'b0);
        check("rst_line_cnt", line_cnt, 0);
        check("rst_cur_buf", cur_buf, 1'b0);
        check("rst_req_ovf", req_ovf, 1'b0);
        check("rst_cmd_en", mcb_cmd_en, 1'b0);
        check("rst_cmd_addr", mcb_cmd_byte_addr, 0);
        check("rst_cmd_instr", mcb_cmd_instr, 3'b011);
        check("rst_rd_en", mcb_rd_en, 1'b0);
        mem_rst_n = 1'b1;
        cyc();

        // ---------------- basic line
        restart(1'b0);
        check("restart_line_cnt", line_cnt, 0);
        clear_all();
        model_line();
        pulse_req();
        wait_lines(1, 300);
        compare_all();
        if (cmd_cyc_q.size() == 4 && word_cyc_q.size() == 32) begin
            check("req_to_cmd", cmd_cyc_q[0] - req_cyc, 3);
            for (int b = 1; b < 4; b++) begin
                check("burst_gap", cmd_cyc_q[b] - word_cyc_q[b * 8 - 1], 2);
            end
        end
        if (done_cyc_q.size() != 0 && word_cyc_q.size() != 0) begin
            check("done_latency", done_cyc_q[0] - word_cyc_q[word_cyc_q.size() - 1], 1);
        end
        check("basic_line_cnt", line_cnt, 1);
        check("basic_busy", busy, 1'b0);
        check("basic_no_ovf", req_ovf, 1'b0);

        // ---------------- frame wrap, with a request landing on consumption
        cfg_lines    = 11'd3;
        cfg_bl       = 6'd3;
        cfg_brst_num = 4'd2;
        restart(1'b0);
        clear_all();
        model_line();
        model_line();
        line_req = 1'b1;
        cyc();
        cyc();
        line_req = 1'b0;
        wait_lines(2, 300);
        check("consume_no_ovf", req_ovf, 1'b0);
        model_line();
        pulse_req();
        wait_lines(3, 300);
        check("wrap_line_cnt", line_cnt, 0);
        model_line();
        pulse_req();
        wait_lines(4, 300);
        compare_all();

        // ---------------- double buffer, base1 bursts wrap the address space
        cfg_bl       = 6'd7;
        cfg_brst_num = 4'd4;
        restart(1'b0);
        clear_all();
        model_line();
        pulse_req();
        wait_lines(1, 300);
        model_line();
        pulse_req();
        repeat (5) cyc();
        frame_sel   = 1'b1;
        frame_start = 1'b1;
        cyc();
        frame_start = 1'b0;
        wait_lines(2, 300);
        repeat (2) cyc();
        model_restart(1'b1);
        check("dbuf_cur_buf", cur_buf, 1'b1);
        check("dbuf_line_cnt", line_cnt, 0);
        model_line();
        pulse_req();
        wait_lines(3, 300);
        compare_all();
        frame_sel = 1'b0;

        // ---------------- backpressure over a 64-word line
        cfg_bl       = 6'd15;
        cfg_brst_num = 4'd4;
        clear_all();
        rnd_bp = 1'b1;
        model_line();
        pulse_req();
        wait_lines(1, 2000);
        rnd_bp = 1'b0;
        check("bp_words", word_q.size(), 64);
        compare_all();

        // ---------------- command full and overrun
        cfg_bl       = 6'd7;
        cfg_brst_num = 4'd2;
        restart(1'b0);
        clear_all();
        mcb_cmd_full = 1'b1;
        model_line();
        pulse_req();
        repeat (12) cyc();
        check("full_no_cmd", cmd_addr_q.size(), 0);
        check("full_busy", busy, 1'b1);
        mcb_cmd_full = 1'b0;
        model_line();
        repeat (3) begin
            line_req = 1'b1;
            cyc();
            line_req = 1'b0;
            cyc();
        end
        check("ovf_set", req_ovf, 1'b1);
        wait_lines(2, 400);
        cyc();
        check("ovf_sticky", req_ovf, 1'b1);
        compare_all();
        restart(1'b0);
        check("ovf_cleared", req_ovf, 1'b0);

        // ---------------- reset mid-line
        restart(1'b1);
        clear_all();
        model_line();
        pulse_req();
        wait_lines(1, 300);
        compare_all();
        clear_all();
        pulse_req();
        repeat (8) cyc();
        check("pre_rst_busy", busy, 1'b1);
        check("pre_rst_line_cnt", line_cnt, 1);
        mem_rst_n = 1'b0;
        #1;
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_rd_en", mcb_rd_en, 1'b0);
        check("mid_rst_out_valid", out_valid, 1'b0);
        check("mid_rst_cmd_en", mcb_cmd_en, 1'b0);
        check("mid_rst_line_cnt", line_cnt, 0);
        check("mid_rst_cur_buf", cur_buf, 1'b0);
        check("mid_rst_cmd_addr", mcb_cmd_byte_addr, 0);
        check("mid_rst_cmd_bl", mcb_cmd_bl, 0);
        cyc();
        check("mid_rst_no_done", done_cyc_q.size(), 0);
        mem_rst_n = 1'b1;
        mq.delete();
        clear_all();
        m_addr = '0; m_line = 0; m_buf = 1'b0;
        cyc();
        model_line();
        pulse_req();
        wait_lines(1, 300);
        compare_all();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
